// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_e;

  // Byte address layout: {tag, index, word offset, byte bit}.
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (ADDR_W - TAG_W));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> (1 + OFF_W));
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] addr);
    return OFF_W'(addr >> 1);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction word storage: one synchronous write port for refills and
// one combinational read port for lookups.
module icache_data_array
  import icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_line_i,
  input  logic [OFF_W-1:0]  wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_line_i,
  input  logic [OFF_W-1:0]  rd_word_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [LINES][WORDS_PER_LINE];

  // NOTE: the storage has no reset; the line valid bits in icache decide
  // whether any of these words mean anything.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_line_i][wr_word_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_line_i][rd_word_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a one-cycle hit path and a
// line refill engine on a word-wide request/acknowledge memory port.
module icache
  import icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache_rd_i,
  input  logic [ADDR_W-1:0] icache_pc_i,
  output logic              icache_valid_o,
  output logic [DATA_W-1:0] icache_instr_o,
  input  logic              invalidate_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [TAG_W-1:0]  line_tag_q, line_tag_d;
  logic [IDX_W-1:0]  line_idx_q, line_idx_d;
  logic              inval_seen_q, inval_seen_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [OFF_W-1:0]  pc_off;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              last_beat;
  logic              arr_we;

  assign pc_tag = tag_of(icache_pc_i);
  assign pc_idx = idx_of(icache_pc_i);
  assign pc_off = off_of(icache_pc_i);

  // An invalidate in the lookup cycle wins over a matching tag.
  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !invalidate_i;
  assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

  icache_data_array u_data (
    .clk_i     (clk_i),
    .we_i      (arr_we),
    .wr_line_i (line_idx_q),
    .wr_word_i (beat_q),
    .wr_data_i (mem_data_i),
    .rd_line_i (pc_idx),
    .rd_word_i (pc_off),
    .rd_data_o (rd_data)
  );

  always_comb begin
    // NOTE: every _d starts from its held value so no path through this
    // block leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    beat_d       = beat_q;
    line_tag_d   = line_tag_q;
    line_idx_d   = line_idx_q;
    inval_seen_d = inval_seen_q;
    out_valid_d  = 1'b0;
    out_instr_d  = out_instr_q;
    arr_we       = 1'b0;

    case (state_q)
      LOOKUP: begin
        if (invalidate_i) begin
          valid_d = '0;
        end
        if (icache_rd_i) begin
          if (hit) begin
            out_valid_d = 1'b1;
            out_instr_d = rd_data;
          end else begin
            line_tag_d   = pc_tag;
            line_idx_d   = pc_idx;
            beat_d       = '0;
            inval_seen_d = 1'b0;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        // The bus transaction always runs to completion; an invalidate only
        // stops the refilled line from becoming valid.
        if (invalidate_i) begin
          valid_d      = '0;
          inval_seen_d = 1'b1;
        end
        if (mem_ack_i) begin
          arr_we = 1'b1;
          beat_d = beat_q + OFF_W'(1);
          if (last_beat) begin
            tag_d[line_idx_q]   = line_tag_q;
            valid_d[line_idx_q] = !(inval_seen_q || invalidate_i);
            state_d             = LOOKUP;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      beat_q       <= '0;
      line_tag_q   <= '0;
      line_idx_q   <= '0;
      inval_seen_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      line_tag_q   <= line_tag_d;
      line_idx_q   <= line_idx_d;
      inval_seen_q <= inval_seen_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
    end
  end

  // Tags are only meaningful behind a set valid bit.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  assign icache_valid_o = out_valid_q;
  assign icache_instr_o = out_instr_q;
  assign mem_req_o      = (state_q == REFILL);
  assign mem_addr_o     = (state_q == REFILL) ? {line_tag_q, line_idx_q, beat_q, 1'b0} : '0;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a cycle-level reference model pushes the
// expected outputs into a queue and a negedge monitor pops and compares them.
module tb_icache;
  import icache_pkg::*;

  localparam int LINE_BYTES = 2 * WORDS_PER_LINE;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        icache_rd_i = 1'b0;
  logic [15:0] icache_pc_i = 16'h0000;
  logic        invalidate_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_data_i = 16'h0000;
  logic        icache_valid_o;
  logic [15:0] icache_instr_o;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  icache dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .icache_rd_i    (icache_rd_i),
    .icache_pc_i    (icache_pc_i),
    .icache_valid_o (icache_valid_o),
    .icache_instr_o (icache_instr_o),
    .invalidate_i   (invalidate_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i)
  );

  // Backing memory, one 16-bit word per even byte address.
  logic [15:0] mem [0:32767];

  typedef struct packed {
    logic        v;
    logic [15:0] instr;
    logic        req;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: which line base address each index holds, plus the
  // progress of the one outstanding refill counted in acknowledged words.
  bit          m_vld [LINES];
  int          m_base[LINES];
  bit          m_busy = 1'b0;
  bit          m_inv  = 1'b0;
  int          m_fill_base = 0;
  int          m_acks = 0;
  logic [15:0] m_instr = 16'h0000;

  int ack_delay  = 0;
  bit rand_delay = 1'b0;
  bit spurious   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   base;
    int   idx;
    int   fidx;
    base = (int'(icache_pc_i) / LINE_BYTES) * LINE_BYTES;
    idx  = (int'(icache_pc_i) / LINE_BYTES) % LINES;
    e.v  = 1'b0;
    if (rst_i) begin
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      m_busy  = 1'b0;
      m_instr = 16'h0000;
    end else if (!m_busy) begin
      e.v = icache_rd_i && !invalidate_i && m_vld[idx] && (m_base[idx] == base);
      if (invalidate_i) foreach (m_vld[i]) m_vld[i] = 1'b0;
      if (e.v) begin
        m_instr = mem[icache_pc_i[15:1]];
      end else if (icache_rd_i) begin
        m_busy      = 1'b1;
        m_inv       = 1'b0;
        m_acks      = 0;
        m_fill_base = base;
      end
    end else begin
      if (invalidate_i) begin
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_inv = 1'b1;
      end
      if (mem_ack_i) begin
        m_acks++;
        if (m_acks == WORDS_PER_LINE) begin
          fidx         = (m_fill_base / LINE_BYTES) % LINES;
          m_base[fidx] = m_fill_base;
          m_vld[fidx]  = !m_inv;
          m_busy       = 1'b0;
        end
      end
    end
    e.instr = m_instr;
    e.req   = m_busy;
    e.addr  = m_busy ? 16'(m_fill_base + 2 * m_acks) : 16'h0000;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  // Monitor: one expected entry per clock cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("icache_valid_o", 16'(icache_valid_o), 16'(e.v));
        check("icache_instr_o", icache_instr_o, e.instr);
        check("mem_req_o", 16'(mem_req_o), 16'(e.req));
        check("mem_addr_o", mem_addr_o, e.addr);
      end
    end
  end

  // Memory responder: acks after ack_delay waiting cycles, optionally
  // throws in acks while no request is pending.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem[mem_addr_o[15:1]];
          wait_cnt   = 0;
          if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spurious && ($urandom_range(0, 3) == 0)) begin
          mem_ack_i  = 1'b1;
          mem_data_i = 16'($urandom);
        end
      end
    end
  end

  task automatic cyc(input logic rd, input logic [15:0] pc, input logic inv);
    icache_rd_i  = rd;
    icache_pc_i  = pc;
    invalidate_i = inv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && (n < budget)) begin
      cyc(icache_rd_i, icache_pc_i, 1'b0);
      n++;
    end
    if (m_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL refill_timeout at %0t: refill still open after %0d cycles", $time, budget);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA55A;
    mem[1] = 16'h5AA5;
    mem[2] = 16'h1234;
    mem[3] = 16'h1111;

    repeat (3) cyc(1'b0, 16'h0000, 1'b0);
    rst_i = 1'b0;

    // Cold miss, then hits on the same line.
    cyc(1'b1, 16'h0000, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0000, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0004, 1'b0);
    cyc(1'b0, 16'h0004, 1'b0);

    // Conflict eviction on index 0.
    cyc(1'b1, 16'h0080, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0080, 1'b0);
    cyc(1'b1, 16'h0000, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0000, 1'b0);

    // Invalidate in lookup, then invalidate during a refill.
    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0002, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0002, 1'b1);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0002, 1'b1);
    wait_idle(50);
    cyc(1'b1, 16'h0002, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0002, 1'b0);

    // Reset after two acks of a refill.
    cyc(1'b1, 16'h0010, 1'b0);
    cyc(1'b1, 16'h0010, 1'b0);
    cyc(1'b1, 16'h0010, 1'b0);
    rst_i = 1'b1;
    cyc(1'b1, 16'h0010, 1'b0);
    rst_i = 1'b0;
    cyc(1'b1, 16'h0000, 1'b0);
    wait_idle(50);
    cyc(1'b1, 16'h0000, 1'b0);

    // Slow memory with a fetch redirect in the middle of the refill.
    ack_delay = 3;
    cyc(1'b1, 16'h0008, 1'b0);
    repeat (5) cyc(1'b1, 16'h0008, 1'b0);
    repeat (3) cyc(1'b1, 16'h0104, 1'b0);
    wait_idle(100);
    cyc(1'b1, 16'h0104, 1'b0);
    wait_idle(100);
    cyc(1'b1, 16'h0104, 1'b0);
    cyc(1'b1, 16'h0008, 1'b0);

    // Random traffic over a few conflicting tags and indices.
    rand_delay = 1'b1;
    spurious   = 1'b1;
    repeat (800) begin
      logic [15:0] pc;
      pc = 16'($urandom_range(0, 2) * 128 + $urandom_range(0, 3) * LINE_BYTES +
               $urandom_range(0, 3) * 2 + $urandom_range(0, 1));
      rst_i = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 39) == 0);
    end
    rst_i    = 1'b0;
    spurious = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0);
    wait_idle(200);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0);
    @(negedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
Direct-mapped, read-only instruction cache. It sits directly upstream of the fetch stage and serves its icache_rd/icache_pc requests with 16-bit instructions. Misses are refilled line-by-line from a simple word-wide memory port using a request/acknowledge handshake. The block is the producer of the icache_valid/icache_instr signals that fetch consumes.

Parameters:
- LINES, 16, number of cache lines; power of 2.
- WORDS_PER_LINE, 4, 16-bit words per line; power of 2, at least 2.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, instruction/word width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- icache_rd_i  in  1  fetch lookup request.
- icache_pc_i  in  ADDR_W  fetch byte address; bit 0 ignored.
- icache_valid_o  out  1  icache_instr_o holds the instruction for the PC looked up last cycle.
- icache_instr_o  out  DATA_W  returned instruction.
- invalidate_i  in  1  one-cycle pulse; clears all line valid bits.
- mem_req_o  out  1  memory word read request.
- mem_addr_o  out  ADDR_W  memory byte address; bit 0 always 0.
- mem_ack_i  in  1  memory returns mem_data_i this cycle.
- mem_data_i  in  DATA_W  memory read data.

Behaviour:
- Address split, shown for the defaults:
  - word offset = pc[2:1] (OFF_W = log2 WORDS_PER_LINE)
  - index = pc[6:3] (IDX_W = log2 LINES)
  - tag = pc[15:7] (TAG_W = ADDR_W - 1 - OFF_W - IDX_W)
- Storage per line: valid bit, tag, WORDS_PER_LINE words.
- Reset values:
  - icache_valid_o = 0, icache_instr_o = 0.
  - mem_req_o = 0, mem_addr_o = 0.
  - all valid bits = 0; state = LOOKUP; beat counter = 0.
- FSM states: LOOKUP, REFILL.
- LOOKUP, icache_rd_i = 1, hit (valid and tag match):
  - next cycle icache_valid_o = 1 and icache_instr_o = the word. Hit latency is 1 cycle.
  - back-to-back hits run every cycle.
- LOOKUP, icache_rd_i = 1, miss:
  - latch the line address (tag, index); next cycle icache_valid_o = 0; go to REFILL with beat = 0.
- LOOKUP, icache_rd_i = 0: next cycle icache_valid_o = 0; icache_instr_o holds its value.
- REFILL:
  - mem_req_o = 1, mem_addr_o = {tag, index, beat, 1'b0}. Address is held stable until mem_ack_i.
  - on mem_ack_i: write mem_data_i into word[beat]; beat++. The request stays high for the next beat with no bubble.
  - on the ack of the last beat: write tag; set valid unless an invalidate occurred during this refill; mem_req_o = 0 next cycle; return to LOOKUP.
  - mem_ack_i with mem_req_o = 0 is ignored.
- During REFILL:
  - icache_valid_o = 0 and icache_rd_i / icache_pc_i are ignored.
  - on return to LOOKUP the current icache_pc_i is looked up again. This makes fetch redirects during a miss safe.
  - miss penalty = WORDS_PER_LINE acks + 1 lookup cycle.
- Refill order is always word 0 first; there is no critical-word-first.
- invalidate_i:
  - in LOOKUP: all valid bits clear at the edge. A lookup in the same cycle is treated as a miss.
  - in REFILL: the refill completes all beats (bus transaction is not abandoned) but the line is left invalid.
- rst_i mid-refill: next cycle mem_req_o = 0, beat = 0, state = LOOKUP, all valid bits clear; partial line data is discarded.
- A miss to the same index with a different tag overwrites the resident line (conflict eviction).

Decomposition:
- icache_pkg:
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters.
  - state enum (LOOKUP, REFILL).
  - address field-extract functions (tag_of, idx_of, off_of).
- Sub-module icache_data_array: LINES × WORDS_PER_LINE × DATA_W storage.
  - one write port (line, word, data, we).
  - one combinational read port.
- Tags, valid bits and the FSM stay in icache.

Test Plan:
1. Cold miss: after reset, rd = 1, pc = 0x0000.
   - icache_valid_o = 0.
   - mem_addr_o steps 0x0000, 0x0002, 0x0004, 0x0006; ack with 0xA55A, 0x5AA5, 0x1234, 0x1111.
   - after the lookup cycle, icache_valid_o = 1 with instr = 0xA55A.
2. Hits: pc = 0x0002 then 0x0004 on consecutive cycles.
   - valid = 1, instr = 0x5AA5 then 0x1234, each 1 cycle later.
   - mem_req_o stays 0.
3. Conflict: pc = 0x0080 (index 0, tag 1).
   - refill at 0x0080..0x0086.
   - then pc = 0x0000 misses again and refetches 0x0000..0x0006.
4. Invalidate: with line 0 resident, pulse invalidate_i, then pc = 0x0002.
   - valid = 0 and a refill starts.
   - repeat with invalidate_i during beat 2 of a refill: afterwards the same pc misses again.
5. Reset mid-refill: assert rst_i after 2 acks.
   - mem_req_o = 0 next cycle.
   - subsequent pc = 0x0000 refills starting at mem_addr_o = 0x0000.
6. Slow memory: delay each ack by 3 cycles.
   - mem_addr_o stable while waiting; icache_valid_o = 0 throughout.
   - change icache_pc_i to 0x0104 mid-refill: after the refill the cache looks up 0x0104 (miss, new refill at 0x0100).
